// File: rtl/m_shreg_pkg.sv
// Shared types for the multi-step shift register: mode codes and FSM states.
// Optional feature macro used by the bundle: M_SHIFT_REGISTER_N_ROTATE_EN.
package m_shreg_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/m_shreg_shifter.sv
// Combinational barrel shifter: one step of SLL/SRL/SRA (and ROR when
// M_SHIFT_REGISTER_N_ROTATE_EN is defined; otherwise mode 11 acts as SRL).
// Ports: q, mode, shamt in; next_q (shifted value), shout (displaced bits,
// right-justified) out.
module m_shreg_shifter
  import m_shreg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 2,
  parameter int SHW     = (1 << SHAMT_W) - 1
) (
  input  logic [WIDTH-1:0]   q,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   next_q,
  output logic [SHW-1:0]     shout
);

  logic [SHW-1:0] low_mask;

  always_comb begin
    low_mask = ~({SHW{1'b1}} << shamt);
    next_q   = q >> shamt;
    shout    = SHW'(q) & low_mask;
    case (mode)
      MODE_SLL: begin
        next_q = q << shamt;
        // shamt=0 shifts by WIDTH, which yields zero
        shout  = SHW'(q >> (WIDTH - int'(shamt)));
      end
      MODE_SRA: begin
        next_q = $unsigned($signed(q) >>> shamt);
      end
`ifdef M_SHIFT_REGISTER_N_ROTATE_EN
      MODE_ROR: begin
        next_q = (q >> shamt) | (q << (WIDTH - int'(shamt)));
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/m_shift_register_n.sv
// Multi-step shift register for mul/div sequencing: load, then N shift steps.
// Ports: clk, clr (sync active-high), start, load_data, steps, shamt, mode,
// we, invert in; data_out, is_zero, shout, busy, done out.
// Macro M_SHIFT_REGISTER_N_ROTATE_EN enables rotate-right for mode 11.
module m_shift_register_n
  import m_shreg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 2,
  parameter int COUNT_W = 6
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        start,
  input  logic [WIDTH-1:0]            load_data,
  input  logic [COUNT_W-1:0]          steps,
  input  logic [SHAMT_W-1:0]          shamt,
  input  logic [1:0]                  mode,
  input  logic                        we,
  input  logic                        invert,
  output logic [WIDTH-1:0]            data_out,
  output logic                        is_zero,
  output logic [(1<<SHAMT_W)-2:0]     shout,
  output logic                        busy,
  output logic                        done
);

  localparam int SHW = (1 << SHAMT_W) - 1;

  state_t               state;
  state_t               state_nx;
  logic [WIDTH-1:0]     q;
  logic [COUNT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt_l;
  logic [1:0]           mode_l;
  logic [SHW-1:0]       shout_r;
  logic [WIDTH-1:0]     sh_q;
  logic [SHW-1:0]       sh_out;

  m_shreg_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .SHW     (SHW)
  ) u_shifter (
    .q      (q),
    .mode   (mode_l),
    .shamt  (shamt_l),
    .next_q (sh_q),
    .shout  (sh_out)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (start)
          state_nx = (steps != '0) ? ST_RUN : ST_DONE;
      end
      state == ST_RUN: begin
        if (cnt == COUNT_W'(1))
          state_nx = ST_DONE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q       <= '0;
      cnt     <= '0;
      shamt_l <= '0;
      mode_l  <= MODE_SLL;
      shout_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            q       <= load_data;
            cnt     <= steps;
            shamt_l <= shamt;
            mode_l  <= mode;
            shout_r <= '0;
          end else if (we) begin
            q <= load_data;
          end
        end
        ST_RUN: begin
          q       <= sh_q;
          shout_r <= sh_out;
          cnt     <= cnt - COUNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out = invert ? ~q : q;
  assign is_zero  = (q == '0);
  assign shout    = shout_r;
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_m_shift_register_n.sv
// Bench for m_shift_register_n: bit-serial reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_m_shift_register_n;
  import m_shreg_pkg::*;

  localparam int W   = 32;
  localparam int SW  = 2;
  localparam int CW  = 6;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic           start = 1'b0;
  logic           we = 1'b0;
  logic           invert = 1'b0;
  logic [W-1:0]   load_data = '0;
  logic [CW-1:0]  steps = '0;
  logic [SW-1:0]  shamt = '0;
  logic [1:0]     mode = 2'b00;
  logic [W-1:0]   data_out;
  logic           is_zero;
  logic [SHW-1:0] shout;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  m_shift_register_n #(
    .WIDTH   (W),
    .SHAMT_W (SW),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .load_data (load_data),
    .steps     (steps),
    .shamt     (shamt),
    .mode      (mode),
    .we        (we),
    .invert    (invert),
    .data_out  (data_out),
    .is_zero   (is_zero),
    .shout     (shout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 done; shifts one bit at a time
  logic [W-1:0]   m_q = '0;
  logic [SHW-1:0] m_shout = '0;
  logic [SHW-1:0] m_o;
  logic [1:0]     m_mode = 2'b00;
  int             m_phase = 0;
  int             m_left = 0;
  int             m_sh = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_q = '0; m_shout = '0; m_phase = 0; m_left = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_q = load_data; m_left = int'(steps);
        m_mode = mode; m_sh = int'(shamt); m_shout = '0;
        m_phase = (steps == 0) ? 2 : 1;
      end else if (we) begin
        m_q = load_data;
      end
    end else if (m_phase == 1) begin
      m_o = '0;
      for (int i = 0; i < m_sh; i++) begin
        case (m_mode)
          2'b00: begin
            m_o = {m_o[SHW-2:0], m_q[W-1]};
            m_q = {m_q[W-2:0], 1'b0};
          end
          2'b10: begin
            m_o[i] = m_q[0];
            m_q = {m_q[W-1], m_q[W-1:1]};
          end
`ifdef M_SHIFT_REGISTER_N_ROTATE_EN
          2'b11: begin
            m_o[i] = m_q[0];
            m_q = {m_q[0], m_q[W-1:1]};
          end
`endif
          default: begin
            m_o[i] = m_q[0];
            m_q = {1'b0, m_q[W-1:1]};
          end
        endcase
      end
      m_shout = m_o;
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("m_data_out", data_out, invert ? ~m_q : m_q);
      check("m_is_zero", is_zero, m_q == '0);
      check("m_shout", shout, m_shout);
      check("m_busy", busy, m_phase == 1);
      check("m_done", done, m_phase == 2);
    end
  end

  task automatic issue(logic [W-1:0] d, int st, int sa, logic [1:0] md);
    load_data = d; steps = CW'(st); shamt = SW'(sa); mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int k0, output int k, output int nbusy);
    k = k0; nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done by cycle 40");
    end
  endtask

  int k, nb, seen;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_is_zero", is_zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_shout", shout, 3'b000);
    invert = 1'b1;
    #1;
    check("rst_inv", data_out, 32'hFFFF_FFFF);
    invert = 1'b0;
    clr = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // SLL by 1, 4 steps
    issue(32'h1, 4, 1, MODE_SLL);
    run_to_done(1, k, nb);
    check("sll_q", data_out, 32'h10);
    check("sll_lat", k, 5);
    check("sll_busy", nb, 4);
    @(negedge clk);

    // SRA radix-4
    issue(32'h8000_0000, 3, 2, MODE_SRA);
    run_to_done(1, k, nb);
    check("sra_q", data_out, 32'hFE00_0000);
    check("sra_shout", shout, 3'b000);
    check("sra_lat", k, 4);
    @(negedge clk);

    issue(32'h3, 1, 2, MODE_SRA);
    run_to_done(1, k, nb);
    check("sra3_q", data_out, 32'h0);
    check("sra3_zero", is_zero, 1'b1);
    check("sra3_shout", shout, 3'b011);
    @(negedge clk);

    // steps = 0
    issue(32'hA5, 0, 1, MODE_SLL);
    run_to_done(1, k, nb);
    check("s0_lat", k, 1);
    check("s0_busy", nb, 0);
    check("s0_q", data_out, 32'hA5);
    @(negedge clk);

    // clr mid-run
    issue(32'hFFFF_0000, 10, 1, MODE_SRL);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_q", data_out, 32'h0);
    check("clr_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("clr_nodone", seen, 0);

    // start/we ignored during RUN
    issue(32'h1, 5, 1, MODE_SLL);
    start = 1'b1; we = 1'b1;
    load_data = 32'hDEAD; steps = CW'(2);
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    @(negedge clk);
    run_to_done(3, k, nb);
    check("ign_q", data_out, 32'h20);
    check("ign_lat", k, 6);
    @(negedge clk);

    // direct write in idle
    we = 1'b1; load_data = 32'h1234_5678;
    @(negedge clk);
    we = 1'b0;
    check("we_q", data_out, 32'h1234_5678);
    check("we_busy", busy, 1'b0);
    @(negedge clk);

    // mode 11
    issue(32'h1, 1, 1, MODE_ROR);
    run_to_done(1, k, nb);
`ifdef M_SHIFT_REGISTER_N_ROTATE_EN
    check("ror_q", data_out, 32'h8000_0000);
`else
    check("ror_q", data_out, 32'h0);
`endif
    check("ror_shout", shout, 3'b001);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_shift_register_n.md
# m_shift_register_n

Parametrised multi-step shift register for the multiply/divide datapath. It loads an operand, then performs a programmed number of shift steps autonomously: left, logical right, or arithmetic right, with a per-step shift amount. It reports busy/done, the bits shifted out in the last step, a zero flag, and an optionally inverted output view. It is the working register for radix-2/radix-4 multiply and divide sequencing.

## Interface
Parameters:
- WIDTH, 32, register width in bits (≥ 4).
- SHAMT_W, 2, width of per-step shift amount; max shift per step = 2^SHAMT_W − 1 (< WIDTH).
- COUNT_W, 6, width of step counter; max steps = 2^COUNT_W − 1.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- clr, in, 1, reset; synchronous, active-high.
- start, in, 1, begin operation (accepted only when busy=0).
- load_data, in, WIDTH, operand loaded on accepted start.
- steps, in, COUNT_W, number of shift steps; sampled on accepted start.
- shamt, in, SHAMT_W, bits shifted per step; sampled on accepted start.
- mode, in, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration); sampled on accepted start.
- we, in, 1, direct write of load_data when idle and start=0.
- invert, in, 1, combinational: data_out = ~q when 1.
- data_out, out, WIDTH, q or ~q.
- is_zero, out, 1, 1 when q (non-inverted) is all zeros.
- shout, out, 2^SHAMT_W−1, bits shifted out in most recent step, right-justified.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse at completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: q←load_data, cnt←steps, latch shamt/mode, shout←0. Next state RUN if steps≠0, else DONE.
- IDLE, start=0, we=1: q←load_data. State stays IDLE. start has priority over we.
- RUN, each cycle: q←shift(q, latched mode, latched shamt), shout←bits displaced, cnt←cnt−1. When cnt=1, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. q holds its value. start is ignored in DONE.
- start and we are ignored while busy=1 or in DONE.
- Shift rules:
  - SLL fills zeros; shout = top shamt bits of the pre-shift q.
  - SRL fills zeros; SRA fills with q[WIDTH−1]. For both, shout = bottom shamt bits.
  - shamt=0 leaves q unchanged, but cnt still decrements and shout←0.
- is_zero is computed from q, independent of invert.

## Timing
- Reset values: q=0, cnt=0, shout=0, state=IDLE, busy=0, done=0; is_zero=1; data_out=0 (or all-ones if invert=1).
- Latency: start in cycle T → q loaded at T+1 edge; busy high T+1..T+steps; done high at T+steps+1. For steps=0, done is at T+1 and busy never rises.
- clr mid-RUN or in DONE: everything returns to reset values on the next edge; no done pulse.
- clr and start in the same cycle: clr wins.
- invert and data_out are purely combinational (zero latency).

## Configuration
- Macro M_SHIFT_REGISTER_N_ROTATE_EN.
- Defined: mode 11 = rotate right by shamt; shout = bits rotated out of the bottom.
- Undefined: rotate logic is not built, and mode 11 behaves exactly as SRL (01).

## Structure
- Package m_shreg_pkg holds:
  - mode codes MODE_SLL/MODE_SRL/MODE_SRA/MODE_ROR as localparams;
  - state encoding ST_IDLE/ST_RUN/ST_DONE.
- Sub-module m_shreg_shifter: combinational barrel shifter taking (q, mode, shamt) and producing (next_q, shout). Parametrised by WIDTH and SHAMT_W; it contains the ROTATE_EN conditional.
- The top level holds the FSM, counter, and registers.

## Test plan
- Reset/idle: assert clr 2 cycles → data_out=0, is_zero=1, busy=0, done=0. With invert=1, data_out=FFFFFFFF.
- SLL: load 0x0000_0001, steps=4, shamt=1, mode=00 → q=0x0000_0010 when done pulses at T+5. busy is high exactly 4 cycles.
- SRA radix-4: load 0x8000_0000, steps=3, shamt=2, mode=10 → q=0xFE00_0000, shout=00, done at T+4. Repeat with load 0x0000_0003 and steps=1 → q=0, is_zero=1, shout=11.
- steps=0 and clr mid-run:
  - start with steps=0 → done at T+1, q=load_data.
  - start with steps=10, clr at T+3 → no done, q=0, state IDLE.
- Ignored inputs: start and we pulsed during RUN do not change q or restart cnt. we in IDLE writes 0x1234_5678 in one cycle.
- Rotate: load 0x0000_0001, steps=1, shamt=1, mode=11.
  - With M_SHIFT_REGISTER_N_ROTATE_EN: q=0x8000_0000, shout=1.
  - Without it: q=0, shout=1.
